// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S frame timer.
package i2s_pkg;

    localparam int unsigned BIT_COUNT_W         = 5;
    localparam int unsigned WORD_BITS           = 32;
    localparam int unsigned DIV_CNT_W           = 8;
    localparam int unsigned CLK_DIV_DEFAULT     = 4;
    localparam int unsigned FRAME_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_frame_timer_bclk_divider.sv
// Divides clk into bclk; flags the clk in which bclk toggles up or down.
module bclk_divider
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_bclk,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [DIV_CNT_W-1:0] r_div_cnt;
    logic                 r_bclk;
    logic                 w_tc;

    assign w_tc     = i_en && (r_div_cnt == DIV_CNT_W'(CLK_DIV - 1));
    assign o_rise_c = w_tc && !r_bclk;
    assign o_fall_c = w_tc && r_bclk;
    assign o_bclk   = r_bclk;

    // Held at zero while disabled so every run starts from a clean phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_frame_timer.sv
// I2S bit/word clock generator with bit counter and serial-data sampler.
// Define I2S_FRAME_COUNT_EN to build the completed-stereo-frame counter.
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int unsigned FRAME_CNT_W = FRAME_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   sdata_in,
    output logic                   bclk,
    output logic                   lrclk,
    output logic [BIT_COUNT_W-1:0] bit_count,
    output logic                   bit_tick,
    output logic                   sdata_s,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    state_e                 r_state;
    logic                   r_lrclk;
    logic [BIT_COUNT_W-1:0] r_bit_count;
    logic                   r_bit_tick;
    logic                   r_sdata_s;
    logic                   r_busy;
    logic                   w_en;
    logic                   w_bclk;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_wrap;

    assign w_en   = (r_state != IDLE);
    assign w_wrap = w_fall && r_lrclk &&
                    (r_bit_count == BIT_COUNT_W'(WORD_BITS - 1));

    bclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_en     (w_en),
        .o_bclk   (w_bclk),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Pulses only occur while enabled, so IDLE naturally holds everything at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lrclk     <= 1'b0;
            r_bit_count <= '0;
            r_bit_tick  <= 1'b0;
            r_sdata_s   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_bit_tick <= w_rise;
            if (w_rise) begin
                r_sdata_s <= sdata_in;
            end
            if (w_fall) begin
                r_bit_count <= r_bit_count + BIT_COUNT_W'(1);
                if (r_bit_count == BIT_COUNT_W'(WORD_BITS - 1)) begin
                    r_lrclk <= ~r_lrclk;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // Re-assertion wins so a late restart never loses a frame.
                    if (run) begin
                        r_state <= RUN;
                    end else if (w_wrap) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_sdata_s   <= 1'b0;
                        r_bit_count <= '0;
                        r_lrclk     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef I2S_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_wrap) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

    assign bclk      = w_bclk;
    assign lrclk     = r_lrclk;
    assign bit_count = r_bit_count;
    assign bit_tick  = r_bit_tick;
    assign sdata_s   = r_sdata_s;
    assign busy      = r_busy;

endmodule
